// File: rtl/cpu_checker.sv
// Serial parser/checker for "^time@pc: $grf <= data#" and "^time@pc: *addr <= data#" trace records.
// Optional: define UPPERCASE_HEX_EN to accept A-F as hex digits in the pc, addr and data fields.
module cpu_checker (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    input  logic [15:0] freq,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_TIME = 4'd1;
    localparam logic [3:0] S_PC   = 4'd2;
    localparam logic [3:0] S_SP0  = 4'd3;
    localparam logic [3:0] S_GRF  = 4'd4;
    localparam logic [3:0] S_ADDR = 4'd5;
    localparam logic [3:0] S_SP1  = 4'd6;
    localparam logic [3:0] S_EQ   = 4'd7;
    localparam logic [3:0] S_DATA = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] time_q, time_d;
    logic [13:0] grf_q, grf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        mem_q, mem_d;
    logic [1:0]  format_q, format_d;
    logic [3:0]  error_q, error_d;

    logic        is_dec, is_hex, is_space;
    logic [3:0]  nib;
    logic        time_err, pc_err, addr_err, grf_err;

    always_comb begin
        is_dec   = (char >= "0") && (char <= "9");
        is_space = (char == " ");
`ifdef UPPERCASE_HEX_EN
        is_hex = is_dec || ((char >= "a") && (char <= "f")) || ((char >= "A") && (char <= "F"));
`else
        is_hex = is_dec || ((char >= "a") && (char <= "f"));
`endif
        // Letters a-f / A-F share low nibbles 1..6, so +9 gives 10..15.
        nib = is_dec ? char[3:0] : char[3:0] + 4'd9;
    end

    always_comb begin
        time_err = (({2'b00, time_q} & ((freq >> 1) - 16'd1)) != 16'd0);
        pc_err   = !((pc_q >= 32'h0000_3000) && (pc_q <= 32'h0000_4fff) && (pc_q[1:0] == 2'b00));
        addr_err = mem_q && !((addr_q <= 32'h0000_2fff) && (addr_q[1:0] == 2'b00));
        grf_err  = !mem_q && (grf_q > 14'd31);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        time_d   = time_q;
        grf_d    = grf_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        mem_d    = mem_q;
        format_d = 2'b00;
        error_d  = 4'b0000;
        if (char == "^") begin
            state_d = S_TIME;
            cnt_d   = 4'd0;
            time_d  = 14'd0;
            grf_d   = 14'd0;
            pc_d    = 32'd0;
            addr_d  = 32'd0;
            mem_d   = 1'b0;
        end else begin
            case (state_q)
                S_TIME: begin
                    if (is_dec && cnt_q < 4'd4) begin
                        time_d = time_q * 14'd10 + {10'd0, char[3:0]};
                        cnt_d  = cnt_q + 4'd1;
                    end else if (char == "@" && cnt_q != 4'd0) begin
                        state_d = S_PC;
                        cnt_d   = 4'd0;
                    end else state_d = S_IDLE;
                end
                S_PC: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        pc_d  = {pc_q[27:0], nib};
                        cnt_d = cnt_q + 4'd1;
                    end else if (char == ":" && cnt_q == 4'd8) begin
                        state_d = S_SP0;
                        cnt_d   = 4'd0;
                    end else state_d = S_IDLE;
                end
                S_SP0: begin
                    if (char == "$") state_d = S_GRF;
                    else if (char == "*") begin
                        state_d = S_ADDR;
                        mem_d   = 1'b1;
                    end else if (!is_space) state_d = S_IDLE;
                end
                // Leading spaces before the first digit are tolerated, e.g. "$ 31".
                S_GRF: begin
                    if (is_dec && cnt_q < 4'd4) begin
                        grf_d = grf_q * 14'd10 + {10'd0, char[3:0]};
                        cnt_d = cnt_q + 4'd1;
                    end else if (is_space && cnt_q == 4'd0) begin
                        state_d = S_GRF;
                    end else if (is_space && cnt_q != 4'd0) state_d = S_SP1;
                    else if (char == "<" && cnt_q != 4'd0) state_d = S_EQ;
                    else state_d = S_IDLE;
                end
                S_ADDR: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        addr_d = {addr_q[27:0], nib};
                        cnt_d  = cnt_q + 4'd1;
                    end else if (is_space && cnt_q == 4'd0) begin
                        state_d = S_ADDR;
                    end else if (is_space && cnt_q == 4'd8) state_d = S_SP1;
                    else if (char == "<" && cnt_q == 4'd8) state_d = S_EQ;
                    else state_d = S_IDLE;
                end
                S_SP1: begin
                    if (char == "<") state_d = S_EQ;
                    else if (!is_space) state_d = S_IDLE;
                end
                S_EQ: begin
                    if (char == "=") begin
                        state_d = S_DATA;
                        cnt_d   = 4'd0;
                    end else state_d = S_IDLE;
                end
                S_DATA: begin
                    if (is_space && cnt_q == 4'd0) state_d = S_DATA;
                    else if (is_hex && cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
                    else if (char == "#" && cnt_q == 4'd8) begin
                        state_d  = S_IDLE;
                        format_d = mem_q ? 2'b10 : 2'b01;
                        error_d  = {grf_err, addr_err, pc_err, time_err};
                    end else state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            time_q   <= 14'd0;
            grf_q    <= 14'd0;
            pc_q     <= 32'd0;
            addr_q   <= 32'd0;
            mem_q    <= 1'b0;
            format_q <= 2'b00;
            error_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            time_q   <= time_d;
            grf_q    <= grf_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            mem_q    <= mem_d;
            format_q <= format_d;
            error_q  <= error_d;
        end
    end

    assign format_type = format_q;
    assign error_code  = error_q;

endmodule

// File: tb/tb_cpu_checker.sv
// Self-checking bench for cpu_checker: expected record results queued per record, compared on output.
module tb_cpu_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [15:0] freq;
    logic [1:0]  format_type;
    logic [3:0]  error_code;

    int checks = 0;
    int errors = 0;
    int spurious;
    logic [5:0] exp_q[$];
    logic [5:0] exp;

    cpu_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .freq        (freq),
        .format_type (format_type),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    // Drives one character per clock; counts nonzero outputs on every cycle but the last.
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            char = s[i];
            @(posedge clk);
            #1;
            if (i < s.len() - 1 && (format_type !== 2'b00 || error_code !== 4'b0000))
                spurious++;
        end
        char = 8'h00;
    endtask

    task automatic record(input string name, input string s, input logic [1:0] f,
                          input logic [3:0] e);
        exp_q.push_back({f, e});
        spurious = 0;
        send(s);
        exp = exp_q.pop_front();
        checks++;
        if ({format_type, error_code} !== exp) begin
            errors++;
            $display("FAIL %s: got %b/%b expected %b/%b", name, format_type, error_code,
                     exp[5:4], exp[3:0]);
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL %s_early: got %0d nonzero cycles expected 0", name, spurious);
        end
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if (format_type !== 2'b00 || error_code !== 4'b0000) begin
            errors++;
            $display("FAIL %s: got %b/%b expected 00/0000", name, format_type, error_code);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        char  = 8'h00;
        freq  = 16'd4;
        repeat (2) @(posedge clk);
        #1;
        expect_idle("reset_state");
        reset = 1'b0;
        // Reset on the same edge as a valid '#' must suppress the output.
        send("^4@00003000:*00000000<=00000000");
        char  = "#";
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        char  = 8'h00;
        expect_idle("reset_on_hash");
    endtask

    task automatic test_mem_back_to_back;
        freq = 16'd32;
        record("rec1", "^5@00008000:*00000088<=ffffb528#", 2'b10, 4'b0011);
        record("rec2", "^5@00003450:*00000088<=ffffb528#", 2'b10, 4'b0001);
        @(posedge clk);
        #1;
        expect_idle("rec2_one_cycle");
    endtask

    task automatic test_reg;
        freq = 16'd4;
        record("reg_ok", "^10@00003000: $ 31 <= 0000abcd#", 2'b01, 4'b0000);
        record("reg_bad", "^10@00003002: $ 32 <= 0000abcd#", 2'b01, 4'b1010);
        record("reg_zeros", "^8@00004ffc:$0031<=00000000#", 2'b01, 4'b0000);
        record("reg_time", "^3@00003004:$7<=00000000#", 2'b01, 4'b0001);
    endtask

    task automatic test_addr;
        freq = 16'd4;
        record("addr_range", "^4@00003000:*00003000<=00000000#", 2'b10, 4'b0100);
        record("addr_align", "^4@00003000:*00000002<=00000000#", 2'b10, 4'b0100);
        record("addr_edge", "^4@00003000:*00002ffc<=00000000#", 2'b10, 4'b0000);
    endtask

    task automatic test_malformed;
        freq = 16'd4;
        record("long_time", "^12345@00003000:*00000000<=00000000#", 2'b00, 4'b0000);
        record("short_pc", "^4@0000300:*00000000<=00000000#", 2'b00, 4'b0000);
        record("split_le", "^4@00003000:*00000000< =00000000#", 2'b00, 4'b0000);
        record("trailing", "^4@00003000:*00000000<=00000000 adf#", 2'b00, 4'b0000);
        record("restart", "^4@00003000:*000^4@00003000: $ 5 <= 00000000#", 2'b01, 4'b0000);
`ifdef UPPERCASE_HEX_EN
        record("upper_hex", "^4@00003000:*00000000<=0000ABCD#", 2'b10, 4'b0000);
`else
        record("upper_hex", "^4@00003000:*00000000<=0000ABCD#", 2'b00, 4'b0000);
`endif
    endtask

    task automatic test_reset_mid;
        freq = 16'd4;
        send("^4@00003000:*000");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_idle("reset_mid_out");
        record("reset_mid_rest", "03000<=00000000#", 2'b00, 4'b0000);
        record("after_reset", "^4@00003000:*00000000<=00000000#", 2'b10, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_mem_back_to_back();
        test_reg();
        test_addr();
        test_malformed();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
